// File: rtl/ram_stream_ctrl_if.sv
// ram_stream_ctrl_if
// Bundles the command, the load stream, the dump stream and the RAM port of
// ram_stream_ctrl.
// master: the controller's view (it drives the RAM port and the stream
//         handshakes).
// slave:  the host/RAM side.
interface ram_stream_ctrl_if #(
    parameter int WIDTH      = 12,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
);
    // Command
    logic                  startLoad;
    logic                  startDump;
    logic [ADDR_WIDTH:0]   wordCount;
    logic                  busy;
    logic                  done;

    // Load stream
    logic [WIDTH-1:0]      inData;
    logic                  inValid;
    logic                  inReady;

    // Dump stream
    logic [WIDTH-1:0]      outData;
    logic                  outValid;
    logic                  outReady;

    // RAM port
    logic                  memWrEn;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [WIDTH-1:0]      memDataIn;
    logic [WIDTH-1:0]      memDataOut;

    modport master (
        input  startLoad, startDump, wordCount,
        input  inData, inValid,
        input  outReady,
        input  memDataOut,
        output busy, done,
        output inReady,
        output outData, outValid,
        output memWrEn, memAddr, memDataIn
    );

    modport slave (
        output startLoad, startDump, wordCount,
        output inData, inValid,
        output outReady,
        output memDataOut,
        input  busy, done,
        input  inReady,
        input  outData, outValid,
        input  memWrEn, memAddr, memDataIn
    );
endinterface

// File: rtl/ram_stream_ctrl.sv
// ram_stream_ctrl
// Initiator-side controller for a single-port data RAM. That RAM registers
// its address, write-enable and data inputs, and its read data comes
// combinationally from the registered address.
// Load phase: accepts a valid/ready stream and writes sequential RAM words.
// Dump phase: reads sequential RAM words out as a valid/ready stream.
module ram_stream_ctrl #(
    parameter int WIDTH      = 12,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstN,
    ram_stream_ctrl_if.master bus
);
    localparam int            CW      = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        DRAIN   = 3'd2,
        RD_ADDR = 3'd3,
        RD_CAP  = 3'd4,
        RD_OUT  = 3'd5
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_ptr;       // current word address, 0 .. cnt-1
    logic [CW-1:0]    r_cnt;       // saturated word count for this transfer
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_done;

    logic [CW-1:0]    w_sat_count;
    logic             w_last;
    logic             w_in_load;
    logic             w_in_read;
    logic             w_in_hs;

    // A count larger than the RAM is clamped, so the address never wraps.
    assign w_sat_count = (bus.wordCount > DEPTH_C) ? DEPTH_C : bus.wordCount;
    assign w_last      = (r_ptr == (r_cnt - ONE_C));
    assign w_in_load   = (r_state == LOAD);
    assign w_in_read   = (r_state == RD_ADDR) || (r_state == RD_CAP) ||
                         (r_state == RD_OUT);
    assign w_in_hs     = w_in_load && bus.inValid;

    // The load path is combinational so that one word per cycle can stream
    // into the RAM. Outside its phase, the RAM port is driven to zero.
    assign bus.inReady   = w_in_load;
    assign bus.memWrEn   = w_in_hs;
    assign bus.memDataIn = w_in_load ? bus.inData : '0;
    assign bus.memAddr   = (w_in_load || w_in_read) ? r_ptr[ADDR_WIDTH-1:0] : '0;
    assign bus.busy      = (r_state != IDLE);
    assign bus.outData   = r_out_data;
    assign bus.outValid  = r_out_valid;
    assign bus.done      = r_done;

    // Transfer sequencer: state, pointer/count and the registered stream/done outputs
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Load wins when both starts arrive together. A zero
                    // count completes at once, without leaving IDLE.
                    if (bus.startLoad || bus.startDump) begin
                        r_cnt <= w_sat_count;
                        r_ptr <= '0;
                        if (w_sat_count == '0) begin
                            r_done <= 1'b1;
                        end else if (bus.startLoad) begin
                            r_state <= LOAD;
                        end else begin
                            r_state <= RD_ADDR;
                        end
                    end
                end

                LOAD: begin
                    if (w_in_hs) begin
                        if (w_last) begin
                            r_state <= DRAIN;
                        end else begin
                            r_ptr <= r_ptr + ONE_C;
                        end
                    end
                end

                DRAIN: begin
                    // The last accepted word commits inside the RAM during
                    // this cycle, so a dump started right after done sees it.
                    r_state <= IDLE;
                    r_done  <= 1'b1;
                end

                RD_ADDR: begin
                    // The RAM registers memAddr at this edge.
                    r_state <= RD_CAP;
                end

                RD_CAP: begin
                    r_out_data  <= bus.memDataOut;
                    r_out_valid <= 1'b1;
                    r_state     <= RD_OUT;
                end

                RD_OUT: begin
                    // outData stays frozen until the consumer takes it.
                    if (bus.outReady) begin
                        r_out_valid <= 1'b0;
                        if (w_last) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_ptr   <= r_ptr + ONE_C;
                            r_state <= RD_ADDR;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_stream_ctrl.sv
// tb_ram_stream_ctrl
// Drives ram_stream_ctrl against a behavioural single-port RAM. The bench's
// own expectation is a memory image of every accepted load word, plus the
// transfer length (wordCount clamped to DEPTH).
module tb_ram_stream_ctrl;
    localparam int WIDTH = 12;
    localparam int DEPTH = 256;
    localparam int AW    = $clog2(DEPTH);

    logic clk  = 1'b0;
    logic rstN = 1'b0;

    ram_stream_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    ram_stream_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // RAM under control: registered inputs, a write one edge later,
    // combinational read from the registered address.
    logic [WIDTH-1:0] ram [0:DEPTH-1];
    logic [AW-1:0]    ram_addr_r;
    logic             ram_we_r;
    logic [WIDTH-1:0] ram_din_r;

    always @(posedge clk) begin
        ram_addr_r <= bus.memAddr;
        ram_we_r   <= bus.memWrEn;
        ram_din_r  <= bus.memDataIn;
        if (ram_we_r) ram[ram_addr_r] <= ram_din_r;
    end
    assign bus.memDataOut = ram[ram_addr_r];

    // Expected memory contents: every word the controller accepted.
    logic [WIDTH-1:0] model_mem [0:DEPTH-1];
    logic [WIDTH-1:0] fix_words [$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"},  32'(bus.busy),      0);
        check_val({tag, "_rdy"},   32'(bus.inReady),   0);
        check_val({tag, "_wr"},    32'(bus.memWrEn),   0);
        check_val({tag, "_addr"},  32'(bus.memAddr),   0);
        check_val({tag, "_din"},   32'(bus.memDataIn), 0);
        check_val({tag, "_oval"},  32'(bus.outValid),  0);
        check_val({tag, "_odat"},  32'(bus.outData),   0);
        check_val({tag, "_done"},  32'(bus.done),      0);
    endtask

    // Load wc words. inValid is either held high or randomly gapped, and
    // startDump is optionally asserted alongside the start and during the load.
    task automatic do_load(input int wc, input bit rand_valid, input bit poke_dump, input bit fixed);
        int eff, idx, cyc;
        logic [WIDTH-1:0] w;
        eff = (wc > DEPTH) ? DEPTH : wc;
        @(negedge clk);
        bus.startLoad = 1'b1;
        bus.startDump = poke_dump;
        bus.wordCount = (AW+1)'(wc);
        bus.inValid   = (eff == 0);
        #1;
        check_val("ld_start_idle", 32'(bus.busy), 0);
        check_val("ld_start_wr", 32'(bus.memWrEn), 0);
        @(negedge clk);
        bus.startLoad = 1'b0;
        bus.startDump = 1'b0;
        if (eff == 0) begin
            #1;
            check_val("zero_busy", 32'(bus.busy), 0);
            check_val("zero_wr", 32'(bus.memWrEn), 0);
            check_val("zero_done", 32'(bus.done), 1);
            @(negedge clk);
            bus.inValid = 1'b0;
            #1;
            check_val("zero_done_clr", 32'(bus.done), 0);
            check_val("zero_busy2", 32'(bus.busy), 0);
            $display("load wc=%0d words=0", wc);
            return;
        end
        idx = 0;
        cyc = 0;
        while (idx < eff && cyc < 3000) begin
            w = fixed ? fix_words[idx] : WIDTH'($urandom);
            bus.inData    = w;
            bus.inValid   = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.startDump = poke_dump ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            check_val("ld_busy", 32'(bus.busy), 1);
            check_val("ld_ready", 32'(bus.inReady), 1);
            check_val("ld_done_early", 32'(bus.done), 0);
            if (bus.inValid) begin
                check_val("ld_wr", 32'(bus.memWrEn), 1);
                check_val("ld_addr", 32'(bus.memAddr), 32'(idx));
                check_val("ld_din", 32'(bus.memDataIn), 32'(w));
                model_mem[idx] = w;
                idx++;
            end else begin
                check_val("ld_wr_idle", 32'(bus.memWrEn), 0);
            end
            @(negedge clk);
            cyc++;
        end
        check_val("ld_count", 32'(idx), 32'(eff));
        bus.inValid   = 1'b0;
        bus.startDump = 1'b0;
        #1;
        check_val("drain_busy", 32'(bus.busy), 1);
        check_val("drain_rdy", 32'(bus.inReady), 0);
        check_val("drain_wr", 32'(bus.memWrEn), 0);
        check_val("drain_done", 32'(bus.done), 0);
        @(negedge clk);
        #1;
        check_val("ld_done", 32'(bus.done), 1);
        check_val("ld_idle", 32'(bus.busy), 0);
        @(negedge clk);
        #1;
        check_val("ld_done_clr", 32'(bus.done), 0);
        check_val("ld_stay_idle", 32'(bus.busy), 0);
        $display("load wc=%0d words=%0d cycles=%0d", wc, idx, cyc);
    endtask

    // Dump wc words. mode 0: outReady always high; 1: high every 4th cycle;
    // 2: random.
    task automatic do_dump(input int wc, input int mode);
        int eff, idx, cyc;
        bit r, prev_stall;
        logic [WIDTH-1:0] prev_data;
        eff = (wc > DEPTH) ? DEPTH : wc;
        @(negedge clk);
        bus.startDump = 1'b1;
        bus.wordCount = (AW+1)'(wc);
        bus.outReady  = 1'b0;
        #1;
        check_val("dp_start_idle", 32'(bus.busy), 0);
        @(negedge clk);
        bus.startDump = 1'b0;
        idx = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        while (idx < eff && cyc < 4000) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = ((cyc % 4) == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            bus.outReady = r;
            #1;
            check_val("dp_busy", 32'(bus.busy), 1);
            check_val("dp_wr", 32'(bus.memWrEn), 0);
            check_val("dp_addr", 32'(bus.memAddr), 32'(idx));
            check_val("dp_done_early", 32'(bus.done), 0);
            if (prev_stall) begin
                check_val("dp_hold_valid", 32'(bus.outValid), 1);
                check_val("dp_hold_data", 32'(bus.outData), 32'(prev_data));
            end
            prev_stall = 1'b0;
            if (bus.outValid) begin
                check_val("dp_data", 32'(bus.outData), 32'(model_mem[idx]));
                if (r) begin
                    if (mode == 0) check_val("dp_latency", 32'(cyc), 32'(2 + 3 * idx));
                    idx++;
                end else begin
                    prev_stall = 1'b1;
                    prev_data  = bus.outData;
                end
            end
            @(negedge clk);
            cyc++;
        end
        check_val("dp_count", 32'(idx), 32'(eff));
        bus.outReady = 1'b0;
        #1;
        check_val("dp_done", 32'(bus.done), 1);
        check_val("dp_idle", 32'(bus.busy), 0);
        check_val("dp_oval_clr", 32'(bus.outValid), 0);
        @(negedge clk);
        #1;
        check_val("dp_done_clr", 32'(bus.done), 0);
        $display("dump wc=%0d words=%0d mode=%0d cycles=%0d", wc, idx, mode, cyc);
    endtask

    initial begin
        int n;
        bus.startLoad = 1'b0;
        bus.startDump = 1'b0;
        bus.wordCount = '0;
        bus.inData    = '0;
        bus.inValid   = 1'b0;
        bus.outReady  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rstN = 1'b1;

        // Four fixed words in, then out with outReady held high
        fix_words = {12'h111, 12'h222, 12'h333, 12'h444};
        do_load(4, 1'b0, 1'b0, 1'b1);
        do_dump(4, 0);

        // Three words out under heavy backpressure
        do_dump(3, 1);

        // Zero-length transfer
        do_load(0, 1'b0, 1'b0, 1'b0);

        // Oversized count clamps to the full RAM
        do_load(300, 1'b0, 1'b0, 1'b0);
        do_dump(300, 2);

        // Simultaneous starts plus startDump noise during the load
        do_load(8, 1'b1, 1'b1, 1'b0);
        do_dump(8, 2);

        // Random lengths with gapped valid and random ready
        for (int k = 0; k < 3; k++) begin
            n = $urandom_range(1, 20);
            do_load(n, 1'b1, 1'b0, 1'b0);
            do_dump(n, 2);
        end

        // Reset in the middle of a 5-word load, after 2 words
        @(negedge clk);
        bus.startLoad = 1'b1;
        bus.wordCount = (AW+1)'(5);
        @(negedge clk);
        bus.startLoad = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.inValid = 1'b1;
            bus.inData  = WIDTH'($urandom);
            #1;
            check_val("abort_rdy", 32'(bus.inReady), 1);
            @(negedge clk);
        end
        bus.inValid = 1'b1;
        rstN = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        bus.inValid = 1'b0;
        #1;
        check_val("abort_no_done", 32'(bus.done), 0);
        rstN = 1'b1;
        $display("abort load after 2 of 5 words");

        fix_words = {12'hABC};
        do_load(1, 1'b0, 1'b0, 1'b1);
        do_dump(1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
